// File: rtl/sync_arbiter.sv
// sync_arbiter: round-robin arbiter that serialises N requesters onto one shared cross-domain channel
module sync_arbiter #(
  parameter int N       = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*DW-1:0]      req_data,
  output logic [N-1:0]         ack,
  output logic [N-1:0]         err,
  output logic                 ch_sig,
  output logic [DW-1:0]        ch_data,
  input  logic                 ch_busy,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 active
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK, FAIL} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic          hit;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          tmo;
  logic [N-1:0]  hot;

  // saturating cycle counter since ch_sig; timeout fires on the cycle it would reach TIMEOUT
  always_comb begin
    cnt_inc = (cnt == TMAX) ? cnt : cnt + CW'(1);
    tmo     = cnt_inc == TMAX;
    hot     = N'(1) << grant_id;
  end

  // round-robin search starting just after the last served requester
  always_comb begin
    pick = last;
    hit  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!hit && req[(int'(last) + k) % N]) begin
        pick = IW'((int'(last) + k) % N);
        hit  = 1'b1;
      end
    end
  end

  // transfer FSM; every output is a flop loaded on the edge entering the state it belongs to
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ack      <= '0;
      err      <= '0;
      ch_sig   <= 1'b0;
      ch_data  <= '0;
      grant_id <= '0;
      active   <= 1'b0;
      cnt      <= '0;
      last     <= IW'(N - 1);
    end else begin
      ch_sig <= 1'b0;
      ack    <= '0;
      err    <= '0;
      case (state)
        IDLE: begin
          if (hit && !ch_busy) begin
            state    <= ISSUE;
            grant_id <= pick;
            ch_data  <= req_data[pick*DW +: DW];
            cnt      <= '0;
            ch_sig   <= 1'b1;
            active   <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
          cnt   <= cnt_inc;
        end
        WAIT_BUSY: begin
          cnt <= cnt_inc;
          if (tmo) begin
            state <= FAIL;
            err   <= hot;
          end else if (ch_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          cnt <= cnt_inc;
          if (tmo) begin
            state <= FAIL;
            err   <= hot;
          end else if (!ch_busy) begin
            state <= ACK;
            ack   <= hot;
          end
        end
        ACK, FAIL: begin
          state  <= IDLE;
          last   <= grant_id;
          active <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sync_arbiter.sv
// tb_sync_arbiter: scoreboard bench for sync_arbiter with a simple channel busy model
module tb_sync_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    bit         is_err;
  } exp_t;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  ack;
  logic [N-1:0]  err;
  logic          ch_sig;
  logic [DW-1:0] ch_data;
  logic          ch_busy;
  logic [1:0]    grant_id;
  logic          active;

  // channel model: mode 0 = busy one cycle after ch_sig for 6 cycles, 1 = stuck busy, 2 = driven by hand
  int   mode = 0;
  logic mdl_busy = 1'b0;
  logic man_busy = 1'b0;
  int   left = 0;
  bit   pend = 1'b0;
  assign ch_busy = (mode == 2) ? man_busy : mdl_busy;

  exp_t       exp_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         nsig = 0;
  int         sig_cyc = 0;
  int         s0 = 0;
  logic [7:0] sig_data = '0;

  sync_arbiter #(.N(N), .DW(DW), .TIMEOUT(16)) dut (
    .CLK(CLK), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .err(err), .ch_sig(ch_sig), .ch_data(ch_data),
    .ch_busy(ch_busy), .grant_id(grant_id), .active(active)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic expect_xfer(int id, logic [7:0] d, bit e);
    exp_t x;
    x.id = 2'(id);
    x.data = d;
    x.is_err = e;
    exp_q.push_back(x);
  endtask

  task automatic set_data(int id, logic [7:0] d);
    req_data[id*DW +: DW] = d;
  endtask

  // observes launches and pops the scoreboard on every ack/err pulse
  task automatic monitor();
    exp_t       e;
    logic [3:0] hv;
    cyc++;
    if (ch_sig) begin
      nsig++;
      sig_cyc = cyc;
      sig_data = ch_data;
    end
    if ((ack | err) != 0) begin
      check("one_hot", $countones(ack | err), 1);
      check("data_hold", ch_data, sig_data);
      if (exp_q.size() == 0) check("unexpected_resp", {ack, err}, 0);
      else begin
        e = exp_q.pop_front();
        hv = 4'b1 << e.id;
        check("grant_id", grant_id, e.id);
        check("ch_data", ch_data, e.data);
        check("resp_kind", {ack, err}, e.is_err ? {4'b0, hv} : {hv, 4'b0});
      end
    end
  endtask

  task automatic model();
    if (mode == 1) begin
      if (ch_sig) mdl_busy = 1'b1;
    end else if (mode == 0) begin
      if (left > 0) begin
        left--;
        if (left == 0) mdl_busy = 1'b0;
      end else if (pend) begin
        mdl_busy = 1'b1;
        left = 6;
        pend = 1'b0;
      end
      if (ch_sig) pend = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    monitor();
    model();
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((ack | err) == 0 && n < 100);
    check("resp_seen", 32'((ack | err) != 0), 1);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_sig", ch_sig, 0);
    check("rst_data", ch_data, 0);
    check("rst_gid", grant_id, 0);
    check("rst_active", active, 0);
    rst_n = 1'b1;

    // single request from requester 2
    set_data(2, 8'hA5);
    expect_xfer(2, 8'hA5, 0);
    req = 4'b0100;
    tick();
    check("sig_lat", ch_sig, 1);
    check("sig_gid", grant_id, 2);
    check("sig_data", ch_data, 8'hA5);
    wait_resp();
    check("ack_lat", cyc - sig_cyc, 8);
    check("ack_vec", ack, 4'b0100);
    req = '0;
    tick();
    check("idle_active", active, 0);

    // timeout with the channel stuck busy, then a blocked grant until busy drops
    set_data(1, 8'h3C);
    expect_xfer(1, 8'h3C, 1);
    mode = 1;
    req = 4'b0010;
    tick();
    check("to_sig", ch_sig, 1);
    wait_resp();
    check("to_lat", cyc - sig_cyc, 16);
    check("to_err", err, 4'b0010);
    set_data(3, 8'hC3);
    expect_xfer(3, 8'hC3, 0);
    req = 4'b1000;
    s0 = nsig;
    repeat (5) tick();
    check("busy_block", nsig - s0, 0);
    mode = 0;
    mdl_busy = 1'b0;
    left = 0;
    pend = 1'b0;
    tick();
    check("resume_sig", ch_sig, 1);
    wait_resp();
    req = '0;
    tick();

    // full contention, each requester drops on its own ack
    for (int i = 0; i < 4; i++) begin
      set_data(i, 8'(8'h10 + i));
      expect_xfer(i, 8'(8'h10 + i), 0);
    end
    req = 4'b1111;
    s0 = nsig;
    repeat (4) begin
      wait_resp();
      req = req & ~(ack | err);
    end
    tick();
    check("cont_sigs", nsig - s0, 4);
    check("cont_drain", exp_q.size(), 0);

    // withdrawal during WAIT_DONE; source data also changes afterwards
    set_data(1, 8'h5A);
    expect_xfer(1, 8'h5A, 0);
    req = 4'b0010;
    tick();
    check("wd_sig", ch_sig, 1);
    repeat (3) tick();
    req = '0;
    set_data(1, 8'hFF);
    wait_resp();
    check("wd_ack", ack, 4'b0010);
    tick();

    // channel busy while idle: no launch until it falls
    mode = 2;
    man_busy = 1'b1;
    set_data(0, 8'h77);
    expect_xfer(0, 8'h77, 0);
    req = 4'b0001;
    s0 = nsig;
    repeat (5) tick();
    check("bi_nosig", nsig - s0, 0);
    man_busy = 1'b0;
    tick();
    check("bi_sig", ch_sig, 1);
    man_busy = 1'b1;
    repeat (2) tick();
    man_busy = 1'b0;
    wait_resp();
    req = '0;
    tick();
    mode = 0;

    // asynchronous reset in the middle of a transfer
    set_data(2, 8'h99);
    req = 4'b0100;
    tick();
    check("ra_sig", ch_sig, 1);
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    check("ra_active", active, 0);
    check("ra_data", ch_data, 0);
    check("ra_gid", grant_id, 0);
    check("ra_resp", {ack, err}, 0);
    req = '0;
    mdl_busy = 1'b0;
    left = 0;
    pend = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    set_data(0, 8'h01);
    set_data(3, 8'h03);
    expect_xfer(0, 8'h01, 0);
    expect_xfer(3, 8'h03, 0);
    req = 4'b1001;
    repeat (2) begin
      wait_resp();
      req = req & ~(ack | err);
    end
    tick();
    check("final_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
